riscv_dmem_ctrl: RTL

//   Parametrised data-memory controller for the next-generation RISC-V core top; replaces the plain single-cycle dmem.

---
 rtl/riscv_dmem_ctrl_if.sv | 24 ++
 rtl/riscv_dmem_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_ctrl_if.sv
// Load/store bus between the core's memory stage and riscv_dmem_ctrl.
// The core (master) drives a request for one cycle; the controller (slave)
// answers with a single-cycle ready pulse that carries rdata and err.
interface riscv_dmem_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, funct3, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// riscv_dmem_ctrl: data-memory controller with req/ready handshake,
// programmable wait states, RV32 byte/half/word accesses with sign
// extension, and error reporting (misaligned, out of range, bad funct3).
// Optional feature macro: DMEM_MMIO_TIMER_EN adds a 64-bit cycle counter
// mapped at MMIO_BASE (+0 low word, +4 high word).
module riscv_dmem_ctrl #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic              clk,
  input  logic              reset,
  riscv_dmem_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] res_q;
  logic        err_q;
  logic [31:0] rdata_r;
  logic        ready_r;
  logic        err_r;
  logic        busy_r;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_half;
  logic          is_word;
  logic          illegal;
  logic          misal;
  logic          high_nz;
  logic          in_win;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word_rd;
  logic [15:0]   sh16;
  logic [31:0]   ld;
  logic          mem_we;
  logic [63:0]   tmr;

`ifdef DMEM_MMIO_TIMER_EN
  localparam bit TIMER_EN = 1'b1;

  logic tmr_clr;
  assign tmr_clr = (state == S_ACCESS) && we_q && in_win && !acc_err && !addr_q[2];

  // Free-running cycle counter; a store to the low word restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        tmr <= '0;
    else if (tmr_clr) tmr <= '0;
    else              tmr <= tmr + 64'd1;
  end
`else
  localparam bit TIMER_EN = 1'b0;

  assign tmr = '0;
`endif

  // Decode of the latched request: errors, lane enables, load extraction
  always_comb begin
    idx     = addr_q[AW+1:2];
    lane    = addr_q[1:0];
    is_half = (f3_q[1:0] == 2'b01);
    is_word = (f3_q[1:0] == 2'b10);
    illegal = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110) || (we_q && f3_q[2]);
    misal   = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
    high_nz = |addr_q[31:AW+2];
    in_win  = TIMER_EN && (addr_q[31:3] == MMIO_BASE[31:3]);
    acc_err = illegal || misal || (high_nz && !in_win) || (in_win && !is_word);

    be    = 4'b0000;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase

    word_rd = in_win ? (addr_q[2] ? tmr[63:32] : tmr[31:0]) : mem[idx];
    sh16    = 16'(word_rd >> {lane, 3'b000});
    case (f3_q[1:0])
      2'b00:   ld = {{24{sh16[7] & ~f3_q[2]}}, sh16[7:0]};
      2'b01:   ld = {{16{sh16[15] & ~f3_q[2]}}, sh16};
      default: ld = word_rd;
    endcase

    mem_we = (state == S_ACCESS) && we_q && !acc_err && !in_win && !reset;
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Request FSM with registered handshake outputs.
  // The access result is held internally during RESP and presented on the
  // edge that leaves RESP, so ready lands WAIT_STATES+2 edges after acceptance
  // and the controller can take the next request in that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      rdata_r <= '0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= '0;
          if (bus.req) begin
            we_q    <= bus.we;
            f3_q    <= bus.funct3;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt     <= 4'(WAIT_STATES);
            busy_r  <= 1'b1;
            state   <= (WAIT_STATES != 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          res_q <= (acc_err || we_q) ? '0 : ld;
          err_q <= acc_err;
          state <= S_RESP;
        end
        S_RESP: begin
          ready_r <= 1'b1;
          rdata_r <= res_q;
          err_r   <= err_q;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;

endmodule
